// File: rtl/multibyte_add_seq.sv
// Wide adder built from one byte adder, LSB first, one byte per clock.
// Optional subtract support is enabled by defining ADD_SEQ_SUB_EN.
module adder_byte (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);
  assign {carry_out, sum} =
    {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
endmodule

module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
  input  logic                sub,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                busy,
  output logic                done
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] res_q;
  logic [CW-1:0]          cnt_q;
  logic                   carry_q;
  logic                   cout_q;
  logic                   ovf_q;

  logic [W-1:0] b_in;
  logic         c_in;

`ifdef ADD_SEQ_SUB_EN
  // a - b == a + ~b + 1
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in       = op_b;
  assign c_in       = cin;
`endif

  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] sum_byte;
  logic       co_byte;
  logic       last;
  logic       accept;

  assign a_byte = a_q[cnt_q];
  assign b_byte = b_q[cnt_q];
  assign last   = (cnt_q == CW'(NBYTES - 1));
  assign accept = (state_q == IDLE) && start;

  adder_byte u_adder (
    .a         (a_byte),
    .b         (b_byte),
    .carry_in  (carry_q),
    .sum       (sum_byte),
    .carry_out (co_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= b_in;
      carry_q <= c_in;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      res_q[cnt_q] <= sum_byte;
      carry_q      <= co_byte;
      cnt_q        <= cnt_q + CW'(1);
      if (last) begin
        cout_q <= co_byte;
        ovf_q  <= (a_byte[7] == b_byte[7]) &&
                  (sum_byte[7] != a_byte[7]);
      end
    end
  end

  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer that performs NBYTES-wide addition by time-multiplexing a single adder_byte instance, one byte per clock, least significant byte first.
- Latches both operands on a start handshake and chains carry_out of each byte into carry_in of the next through a carry register.
- Reports the full-width result, final carry and signed overflow with a one-cycle done pulse.
- Sits between the ALU control and the byte adder, so wide arithmetic reuses one 8-bit datapath.

Parameters:
- NBYTES, 4, operand width in bytes (≥1); total width W = 8*NBYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  W  first operand; sampled on accepted start.
- op_b  input  W  second operand; sampled on accepted start.
- cin  input  1  initial carry-in; sampled on accepted start.
- sub  input  1  subtract request; only functional with ADD_SEQ_SUB_EN.
- result  output  W  sum; held from done until the next accepted start.
- carry_out  output  1  carry out of the MSB byte.
- overflow  output  1  signed overflow of the W-bit operation.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset: state=IDLE, byte counter=0, carry register=0, operand registers=0. Outputs result, carry_out, overflow, busy and done are all 0.
- IDLE: busy=0, done=0. If start=1 at a clk edge, latch op_a, op_b and cin into the operand and carry registers, set counter=0, go to RUN.
- RUN:
  - adder_byte inputs are a=A[8*cnt+:8], b=B[8*cnt+:8], carry_in=carry register.
  - At each edge: write sum into result[8*cnt+:8], load carry register with the adder's carry_out, increment cnt.
  - When cnt==NBYTES-1 at that edge: also capture carry_out, compute overflow, go to DONE.
  - overflow = (a[7]==b[7]) && (sum[7]!=a[7]) on the MSB byte, using the effective (possibly inverted) b.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; done is high during the cycle after edge k+NBYTES. Throughput is one operation per NBYTES+2 cycles.
- start while busy: ignored, not queued. Operands and result are unaffected.
- start held high continuously: a new operation is accepted on each return to IDLE.
- Result bytes update progressively during RUN. result, carry_out and overflow are valid only from done onward.
- carry_out and overflow hold their last values until the next operation's final byte.
- NBYTES=1: RUN lasts one cycle; behaviour is identical to a registered adder_byte.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced for the aborted operation.
- Arithmetic is modulo 2^W; there are no saturation modes.

Optional Feature:
- Macro: ADD_SEQ_SUB_EN.
- Defined: sub=1 at an accepted start latches ~op_b into B and forces the initial carry to 1, ignoring cin. result = op_a - op_b mod 2^W. carry_out=1 means no borrow; overflow is signed subtract overflow. sub=0 gives addition as normal.
- Undefined: sub is ignored, B=op_b, initial carry=cin, and there is no extra logic on the B path.

Test Plan:
- NBYTES=4, op_a=0x000000FF, op_b=0x00000001, cin=0, start at edge k -> result=0x00000100, carry_out=0, overflow=0, done high only in the cycle after edge k+4, busy high for 5 cycles.
- op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> result=0x00000000, carry_out=1, overflow=0 (carry ripples through all 4 bytes).
- op_a=0x7FFFFFFF, op_b=0x00000001, cin=0 -> result=0x80000000, carry_out=0, overflow=1.
- After start of 0x11111111+0x22222222, pulse start with 0xFFFFFFFF+0xFFFFFFFF during RUN -> second start ignored; done once with result=0x33333333, then busy=0.
- rst_n low for 1 cycle after 2 RUN cycles -> all outputs 0 immediately, state IDLE, no done; a following start of 5+7 gives result=0x0000000C.
- With ADD_SEQ_SUB_EN: sub=1, op_a=0x00000000, op_b=0x00000001 -> result=0xFFFFFFFF, carry_out=0 (borrow). Also op_a=0x80000000, op_b=0x00000001 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
